// File: rtl/urna_pkg.sv
// Shared types and constants for the voter-session controller and its helpers.
package urna_pkg;

    localparam int DIGIT_W = 4;
    localparam int COUNT_W = 8;
    localparam logic [2:0] MAX_DIGITS = 3'd4;

    typedef logic [2:0] dcount_t;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_ENTRY  = 3'd1,
        S_CHECK1 = 3'd2,
        S_CHECK2 = 3'd3,
        S_SHOW   = 3'd4,
        S_LOCKED = 3'd5
    } sess_state_t;

endpackage

// File: rtl/urna_sessao_ctrl_if.sv
// Strobe/status link between the session controller (master) and urna_module (slave).
interface urna_sessao_ctrl_if;
    import urna_pkg::*;

    // Valid, Next and Finish are single-cycle strobes with no back-pressure; the
    // slave acts on them at the next rising edge. Digit is meaningful only while
    // Valid is high. StatusValido (1 = valid vote) and StatusNulo (0 = null vote)
    // are levels the master samples while deciding.
    logic [DIGIT_W-1:0] Digit;
    logic               Valid;
    logic               Next;
    logic               Finish;
    logic               StatusValido;
    logic               StatusNulo;

    modport master (
        output Digit, Valid, Next, Finish,
        input  StatusValido, StatusNulo
    );

    modport slave (
        input  Digit, Valid, Next, Finish,
        output StatusValido, StatusNulo
    );

endinterface

// File: rtl/urna_key_hold.sv
// Rising-edge detector plus saturating hold counter for a debounced key level.
module urna_key_hold #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key,
    output logic rise,
    output logic hold_done
);

    localparam logic [31:0] HOLD_LAST = HOLD_CYCLES - 1;

    logic        key_q;
    logic [31:0] hold_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            key_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            key_q <= key;
            if (!key) begin
                hold_cnt <= '0;
            end else if (hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 32'd1;
            end
        end
    end

    assign rise = key & ~key_q;
    // Matches only once per press: the counter moves past HOLD_LAST and saturates.
    assign hold_done = key && (hold_cnt == HOLD_LAST);

endmodule

// File: rtl/urna_sessao_ctrl.sv
// Voter-session controller: key strobes into urna_module, result display, timeout, quota.
module urna_sessao_ctrl
    import urna_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES        = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES     = 500_000_000,
    parameter int unsigned FINISH_HOLD_CYCLES = 150_000_000,
    parameter int unsigned MAX_VOTERS         = 255
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               KeyEnter,
    input  logic               KeyFinish,
    input  logic [DIGIT_W-1:0] DigitIn,
    urna_sessao_ctrl_if.master urna,
    output dcount_t            DigitCount,
    output logic               ShowValid,
    output logic               ShowNulo,
    output logic               TimeoutFlag,
    output logic [COUNT_W-1:0] VoterCount,
    output logic               Locked,
    output sess_state_t        debug_state
);

    localparam logic [31:0]        HOLD_LAST    = HOLD_CYCLES - 1;
    localparam logic [31:0]        TIMEOUT_LAST = TIMEOUT_CYCLES - 1;
    localparam logic [COUNT_W-1:0] QUOTA        = COUNT_W'(MAX_VOTERS);

    sess_state_t        state;
    logic [31:0]        idle_cnt;
    logic [31:0]        hold_cnt;
    logic [DIGIT_W-1:0] digit_q;
    logic               valid_q, next_q, finish_q;
    logic               enter_rise, finish_done;
    logic               unused_enter_hold, unused_finish_rise;

    urna_key_hold #(.HOLD_CYCLES(1)) u_enter (
        .Clock(Clock), .Reset(Reset), .key(KeyEnter),
        .rise(enter_rise), .hold_done(unused_enter_hold)
    );

    urna_key_hold #(.HOLD_CYCLES(FINISH_HOLD_CYCLES)) u_finish (
        .Clock(Clock), .Reset(Reset), .key(KeyFinish),
        .rise(unused_finish_rise), .hold_done(finish_done)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_INIT;
            idle_cnt    <= '0;
            hold_cnt    <= '0;
            digit_q     <= '0;
            valid_q     <= 1'b0;
            next_q      <= 1'b0;
            finish_q    <= 1'b0;
            DigitCount  <= '0;
            ShowValid   <= 1'b0;
            ShowNulo    <= 1'b0;
            TimeoutFlag <= 1'b0;
            VoterCount  <= '0;
            Locked      <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            next_q      <= 1'b0;
            finish_q    <= 1'b0;
            TimeoutFlag <= 1'b0;
            if (finish_done) begin
                // Admin close wins over whatever the session was doing.
                finish_q   <= 1'b1;
                VoterCount <= '0;
                Locked     <= 1'b0;
                DigitCount <= '0;
                ShowValid  <= 1'b0;
                ShowNulo   <= 1'b0;
                idle_cnt   <= '0;
                hold_cnt   <= '0;
                state      <= S_ENTRY;
            end else begin
                case (state)
                    S_INIT: begin
                        finish_q <= 1'b1;
                        state    <= S_ENTRY;
                    end
                    S_ENTRY: begin
                        if (enter_rise) begin
                            digit_q    <= DigitIn;
                            valid_q    <= 1'b1;
                            DigitCount <= DigitCount + 3'd1;
                            idle_cnt   <= '0;
                            state      <= S_CHECK1;
                        end else if (DigitCount != '0) begin
                            if (idle_cnt == TIMEOUT_LAST) begin
                                next_q      <= 1'b1;
                                TimeoutFlag <= 1'b1;
                                DigitCount  <= '0;
                                idle_cnt    <= '0;
                            end else if (idle_cnt != '1) begin
                                idle_cnt <= idle_cnt + 32'd1;
                            end
                        end
                    end
                    S_CHECK1: state <= S_CHECK2;
                    S_CHECK2: begin
                        hold_cnt <= '0;
                        if (!urna.StatusNulo) begin
                            ShowNulo <= 1'b1;
                            state    <= S_SHOW;
                        end else if (urna.StatusValido) begin
                            ShowValid <= 1'b1;
                            state     <= S_SHOW;
                        end else if (DigitCount < MAX_DIGITS) begin
                            state <= S_ENTRY;
                        end else begin
                            // Four digits and no verdict: release urna_module, count nothing.
                            next_q <= 1'b1;
                            state  <= S_SHOW;
                        end
                    end
                    S_SHOW: begin
                        if (hold_cnt == HOLD_LAST) begin
                            ShowValid  <= 1'b0;
                            ShowNulo   <= 1'b0;
                            DigitCount <= '0;
                            next_q     <= ShowValid;
                            state      <= S_ENTRY;
                            if (ShowValid || ShowNulo) begin
                                if (VoterCount != '1) VoterCount <= VoterCount + 8'd1;
                                if (VoterCount + 8'd1 >= QUOTA) begin
                                    Locked <= 1'b1;
                                    state  <= S_LOCKED;
                                end
                            end
                        end else if (hold_cnt != '1) begin
                            hold_cnt <= hold_cnt + 32'd1;
                        end
                    end
                    S_LOCKED: Locked <= 1'b1;
                    default:  state  <= S_INIT;
                endcase
            end
        end
    end

    assign urna.Digit  = digit_q;
    assign urna.Valid  = valid_q;
    assign urna.Finish = finish_q;
    // urna_module counts a null vote on every cycle it sits in its null state,
    // so Next must be asserted in the very cycle StatusNulo first reads 0.
    assign urna.Next   = next_q | ((state == S_CHECK2) && !urna.StatusNulo && !finish_done);
    assign debug_state = state;

endmodule

// File: tb/tb_urna_sessao_ctrl.sv
// Directed bench for urna_sessao_ctrl with a behavioural urna_module on the slave side.
module tb_urna_sessao_ctrl;
  import urna_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_enter = 1'b0;
  logic key_finish = 1'b0;
  logic [3:0] digit_in = 4'd0;
  dcount_t digit_count;
  logic show_valid, show_nulo, timeout_flag, locked;
  logic [7:0] voter_count;
  sess_state_t debug_state;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  urna_sessao_ctrl_if urna();

  urna_sessao_ctrl #(
    .HOLD_CYCLES(8), .TIMEOUT_CYCLES(20), .FINISH_HOLD_CYCLES(5), .MAX_VOTERS(2)
  ) dut (
    .Clock(clk), .Reset(rst), .KeyEnter(key_enter), .KeyFinish(key_finish),
    .DigitIn(digit_in), .urna(urna), .DigitCount(digit_count),
    .ShowValid(show_valid), .ShowNulo(show_nulo), .TimeoutFlag(timeout_flag),
    .VoterCount(voter_count), .Locked(locked), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  logic [21:0] all_outs;
  assign all_outs = {urna.Valid, urna.Next, urna.Finish, show_valid, show_nulo,
                     timeout_flag, locked, voter_count, digit_count, urna.Digit};

  // urna_module model: four candidate codes, null on first non-matching prefix.
  logic [15:0] cand [4];
  int m_state = 0;
  int m_pos = 0;
  logic [15:0] m_code = 16'h0;
  int nulo = 0;
  int c [4] = '{default: 0};

  function automatic int prefix_match(input logic [15:0] code, input int n);
    logic ok;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b1;
      for (int j = 0; j < n; j++)
        if (cand[k][15-4*j -: 4] != code[15-4*j -: 4]) ok = 1'b0;
      if (ok) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : urna_model
    logic [15:0] ncode;
    int k;
    if (urna.Finish === 1'b1) begin
      m_state <= 0; m_pos <= 0; m_code <= 16'h0; nulo <= 0;
      for (int i = 0; i < 4; i++) c[i] <= 0;
    end else if (urna.Next === 1'b1) begin
      m_state <= 0; m_pos <= 0; m_code <= 16'h0;
    end else if (m_state == 2) begin
      nulo <= nulo + 1;
    end else if (urna.Valid === 1'b1 && m_state == 0 && m_pos < 4) begin
      ncode = m_code;
      ncode[15-4*m_pos -: 4] = urna.Digit;
      k = prefix_match(ncode, m_pos + 1);
      m_code <= ncode;
      m_pos <= m_pos + 1;
      if (k < 0) begin
        m_state <= 2; nulo <= nulo + 1;
      end else if (m_pos == 3) begin
        m_state <= 1; c[k] <= c[k] + 1;
      end
    end
  end

  assign urna.StatusValido = (m_state == 1);
  assign urna.StatusNulo = (m_state != 2);

  always @(negedge clk) if (urna.Valid === 1'b1 && urna.Next === 1'b1) overlap++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge while in ENTRY; returns at the negedge of the Valid cycle.
  task automatic press_key(input logic [3:0] d, output logic got, output logic [3:0] seen);
    got = 1'b0;
    seen = 4'd0;
    digit_in = d;
    key_enter = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!got) begin
        @(negedge clk);
        key_enter = 1'b0;
        if (urna.Valid === 1'b1) begin
          got = 1'b1;
          seen = urna.Digit;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== 22'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (urna.Finish !== 1'b1) begin
      errors++; $display("FAIL init_finish: got %b expected 1", urna.Finish);
    end
    @(negedge clk);
    checks++;
    if (urna.Finish !== 1'b0 || debug_state !== S_ENTRY) begin
      errors++; $display("FAIL init_finish_once: finish %b state %0d expected 0 and %0d",
                         urna.Finish, debug_state, S_ENTRY);
    end
  endtask

  task automatic test_valid_vote;
    logic [3:0] keys [4];
    logic got;
    logic [3:0] seen;
    int sv, sn, nx;
    keys[0] = 4'd3; keys[1] = 4'd4; keys[2] = 4'd9; keys[3] = 4'd4;
    for (int i = 0; i < 4; i++) begin
      press_key(keys[i], got, seen);
      checks++;
      if (!got || seen !== keys[i]) begin
        errors++; $display("FAIL valid_digit%0d: got valid %b digit %0d expected digit %0d", i, got, seen, keys[i]);
      end
      if (i < 3) begin
        @(negedge clk);
        checks++;
        if (urna.Valid !== 1'b0) begin
          errors++; $display("FAIL valid_one_cycle: got %b expected 0", urna.Valid);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (digit_count !== 3'd4) begin
      errors++; $display("FAIL valid_digit_count: got %0d expected 4", digit_count);
    end
    sv = 0; sn = 0; nx = 0;
    repeat (14) begin
      @(negedge clk);
      if (show_valid) sv++;
      if (show_nulo) sn++;
      if (urna.Next) nx++;
    end
    checks++;
    if (sv != 8 || sn != 0 || nx != 1) begin
      errors++; $display("FAIL valid_show: got show_valid %0d show_nulo %0d next %0d expected 8 0 1", sv, sn, nx);
    end
    checks++;
    if (c[0] != 1 || voter_count !== 8'd1 || digit_count !== 3'd0) begin
      errors++; $display("FAIL valid_counts: got c1 %0d voters %0d digits %0d expected 1 1 0", c[0], voter_count, digit_count);
    end
  endtask

  task automatic test_finish_hold;
    int fc;
    fc = 0;
    key_finish = 1'b1;
    repeat (4) begin @(negedge clk); if (urna.Finish) fc++; end
    key_finish = 1'b0;
    repeat (3) begin @(negedge clk); if (urna.Finish) fc++; end
    checks++;
    if (fc != 0) begin
      errors++; $display("FAIL finish_short_hold: got %0d pulses expected 0", fc);
    end
    key_finish = 1'b1;
    repeat (8) begin @(negedge clk); if (urna.Finish) fc++; end
    key_finish = 1'b0;
    repeat (3) begin @(negedge clk); if (urna.Finish) fc++; end
    checks++;
    if (fc != 1) begin
      errors++; $display("FAIL finish_long_hold: got %0d pulses expected 1", fc);
    end
    checks++;
    if (voter_count !== 8'd0 || (c[0] + c[1] + c[2] + c[3] + nulo) != 0) begin
      errors++; $display("FAIL finish_clear: got voters %0d urna total %0d expected 0 0",
                         voter_count, c[0] + c[1] + c[2] + c[3] + nulo);
    end
  endtask

  task automatic test_early_null;
    logic got;
    logic [3:0] seen;
    int sn, nx;
    press_key(4'd2, got, seen);
    checks++;
    if (!got || seen !== 4'd2 || urna.Next !== 1'b0) begin
      errors++; $display("FAIL null_valid: got valid %b digit %0d next %b expected 1 2 0", got, seen, urna.Next);
    end
    @(negedge clk);
    checks++;
    if (urna.StatusNulo !== 1'b0 || urna.Next !== 1'b1) begin
      errors++; $display("FAIL null_next_cycle: got nulo %b next %b expected 0 1", urna.StatusNulo, urna.Next);
    end
    sn = 0; nx = 0;
    repeat (12) begin
      @(negedge clk);
      if (show_nulo) sn++;
      if (urna.Next) nx++;
    end
    checks++;
    if (sn != 8 || nx != 0) begin
      errors++; $display("FAIL null_show: got show_nulo %0d next %0d expected 8 0", sn, nx);
    end
    checks++;
    if (nulo != 1 || voter_count !== 8'd1) begin
      errors++; $display("FAIL null_counts: got nulo %0d voters %0d expected 1 1", nulo, voter_count);
    end
  endtask

  task automatic test_timeout;
    logic got;
    logic [3:0] seen;
    logic tf, nx;
    int k;
    press_key(4'd3, got, seen);
    repeat (2) @(negedge clk);
    press_key(4'd5, got, seen);
    checks++;
    if (!got || digit_count !== 3'd2) begin
      errors++; $display("FAIL timeout_digits: got valid %b digits %0d expected 1 2", got, digit_count);
    end
    tf = 1'b0; nx = 1'b0; k = 0;
    while (k < 40 && !tf) begin
      @(negedge clk);
      k++;
      if (timeout_flag) begin tf = 1'b1; nx = urna.Next; end
    end
    checks++;
    if (!tf || k != 22 || nx !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse: got flag %b after %0d cycles next %b expected 1 22 1", tf, k, nx);
    end
    @(negedge clk);
    checks++;
    if (digit_count !== 3'd0 || timeout_flag !== 1'b0 || urna.Next !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got digits %0d flag %b next %b expected 0 0 0",
                         digit_count, timeout_flag, urna.Next);
    end
    checks++;
    if ((c[0] + c[1] + c[2] + c[3]) != 0 || nulo != 1 || voter_count !== 8'd1) begin
      errors++; $display("FAIL timeout_counts: got cands %0d nulo %0d voters %0d expected 0 1 1",
                         c[0] + c[1] + c[2] + c[3], nulo, voter_count);
    end
  endtask

  task automatic test_quota;
    logic [3:0] keys [4];
    logic got;
    logic [3:0] seen;
    int fc;
    keys[0] = 4'd3; keys[1] = 4'd5; keys[2] = 4'd1; keys[3] = 4'd2;
    for (int i = 0; i < 4; i++) begin
      press_key(keys[i], got, seen);
      if (i < 3) repeat (2) @(negedge clk);
    end
    repeat (14) @(negedge clk);
    checks++;
    if (c[1] != 1 || voter_count !== 8'd2 || locked !== 1'b1 || debug_state !== S_LOCKED) begin
      errors++; $display("FAIL quota_lock: got c2 %0d voters %0d locked %b state %0d expected 1 2 1 %0d",
                         c[1], voter_count, locked, debug_state, S_LOCKED);
    end
    press_key(4'd7, got, seen);
    checks++;
    if (got !== 1'b0) begin
      errors++; $display("FAIL locked_no_valid: got valid %b expected 0", got);
    end
    fc = 0;
    key_finish = 1'b1;
    repeat (7) begin @(negedge clk); if (urna.Finish) fc++; end
    key_finish = 1'b0;
    repeat (2) begin @(negedge clk); if (urna.Finish) fc++; end
    checks++;
    if (fc != 1 || locked !== 1'b0 || voter_count !== 8'd0 || debug_state !== S_ENTRY) begin
      errors++; $display("FAIL quota_unlock: got finish %0d locked %b voters %0d state %0d expected 1 0 0 %0d",
                         fc, locked, voter_count, debug_state, S_ENTRY);
    end
  endtask

  task automatic test_check_ignore;
    logic got;
    logic [3:0] seen;
    int vc;
    press_key(4'd2, got, seen);
    @(negedge clk);
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    vc = 0;
    repeat (14) begin @(negedge clk); if (urna.Valid) vc++; end
    checks++;
    if (vc != 0 || voter_count !== 8'd1) begin
      errors++; $display("FAIL check_key_ignored: got valid %0d voters %0d expected 0 1", vc, voter_count);
    end
  endtask

  task automatic test_reset_mid_show;
    logic got;
    logic [3:0] seen;
    press_key(4'd2, got, seen);
    repeat (4) @(negedge clk);
    checks++;
    if (show_nulo !== 1'b1 || debug_state !== S_SHOW) begin
      errors++; $display("FAIL pre_reset_show: got show_nulo %b state %0d expected 1 %0d", show_nulo, debug_state, S_SHOW);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs !== 22'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (urna.Finish !== 1'b1) begin
      errors++; $display("FAIL mid_reset_finish: got %b expected 1", urna.Finish);
    end
    @(negedge clk);
    checks++;
    if (nulo != 0 || urna.Finish !== 1'b0) begin
      errors++; $display("FAIL mid_reset_urna_clear: got nulo %0d finish %b expected 0 0", nulo, urna.Finish);
    end
  endtask

  task automatic test_no_overlap;
    checks++;
    if (overlap != 0) begin
      errors++; $display("FAIL valid_next_overlap: got %0d cycles expected 0", overlap);
    end
  endtask

  initial begin
    cand[0] = 16'h3494;
    cand[1] = 16'h3512;
    cand[2] = 16'h7777;
    cand[3] = 16'h1234;
    test_reset();
    test_valid_vote();
    test_finish_hold();
    test_early_null();
    test_timeout();
    test_quota();
    test_check_ignore();
    test_reset_mid_show();
    test_no_overlap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
